// File: rtl/uart_frame_collector_if.sv
// ----------------------------------------------------------------------------
// uart_frame_collector_if
//   Bundles the signals between the uartRx/TX/arbiter side and the frame
//   collector, plus the ramUART write port the collector drives.
//
//   master : the surroundings (TX arm, uartRx strobe/data, read arbiter
//            release). It drives the i* signals and observes the o* signals.
//   slave  : the collector itself.
//
//   Signals
//     iArm      1-cycle pulse, request just sent, open a new frame
//     iValid    1-cycle byte strobe from uartRx
//     iData     received byte, valid with iValid
//     iRelease  1-cycle pulse from the read arbiter, buffer consumed
//     oWrAddr   ramUART write address
//     oWrData   ramUART write data
//     oWE       ramUART write enable
//     oDone     1-cycle pulse, frame closed and buffer ready
//     oLen      number of valid bytes in the closed frame
//     oTimeout  1-cycle pulse, frame closed or abandoned by timeout
//     oOverrun  sticky, data or arm arrived while the buffer was locked
// ----------------------------------------------------------------------------
interface uart_frame_collector_if #(
    parameter int ADDR_W = 5
);
    logic              iArm;
    logic              iValid;
    logic [7:0]        iData;
    logic              iRelease;
    logic [ADDR_W-1:0] oWrAddr;
    logic [7:0]        oWrData;
    logic              oWE;
    logic              oDone;
    logic [ADDR_W:0]   oLen;
    logic              oTimeout;
    logic              oOverrun;

    modport master (
        output iArm,
        output iValid,
        output iData,
        output iRelease,
        input  oWrAddr,
        input  oWrData,
        input  oWE,
        input  oDone,
        input  oLen,
        input  oTimeout,
        input  oOverrun
    );

    modport slave (
        input  iArm,
        input  iValid,
        input  iData,
        input  iRelease,
        output oWrAddr,
        output oWrData,
        output oWE,
        output oDone,
        output oLen,
        output oTimeout,
        output oOverrun
    );
endinterface

// File: rtl/uart_frame_collector.sv
// ----------------------------------------------------------------------------
// uart_frame_collector
//   Sits between a uartRx receiver and its ramUART buffer. Once armed by the
//   TX side it writes incoming bytes to consecutive buffer addresses, closes
//   the frame when FRAME_LEN bytes arrived or when the line stayed silent for
//   TIMEOUT_CYC cycles, pulses oDone with the frame length and then keeps the
//   buffer locked until the read arbiter releases it.
//
//   Ports
//     clk   clk80MHz domain clock
//     rst   synchronous, active-high reset (aborts any frame in progress)
//     bus   uart_frame_collector_if.slave (arm/byte/release in, ramUART
//           write port and frame status out)
//
//   All outputs come straight from registers.
// ----------------------------------------------------------------------------
module uart_frame_collector #(
    parameter int ADDR_W      = 5,
    parameter int FRAME_LEN   = 16,
    parameter int TIMEOUT_CYC = 400
) (
    input  logic                   clk,
    input  logic                   rst,
    uart_frame_collector_if.slave  bus
);

    localparam int              TMR_W       = $clog2(TIMEOUT_CYC + 1);
    localparam logic [ADDR_W:0] FRAME_LEN_C = (ADDR_W + 1)'(FRAME_LEN);
    localparam logic [TMR_W-1:0] TMR_LAST   = TMR_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        CLOSE   = 2'd2,
        LOCKED  = 2'd3
    } state_t;

    state_t            state_q,   state_d;
    logic [ADDR_W:0]   cnt_q,     cnt_d;
    logic [TMR_W-1:0]  timer_q,   timer_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic              we_q,      we_d;
    logic              done_q,    done_d;
    logic [ADDR_W:0]   len_q,     len_d;
    logic              timeout_q, timeout_d;
    logic              overrun_q, overrun_d;

    logic [ADDR_W:0]   cnt_inc;

    // Silence timer advances by one and parks at its last value so it can
    // never wrap back into a fresh count while waiting.
    function automatic logic [TMR_W-1:0] timer_sat_inc(input logic [TMR_W-1:0] t);
        if (t == TMR_LAST) begin
            return t;
        end
        return t + TMR_W'(1);
    endfunction

    assign cnt_inc = cnt_q + (ADDR_W + 1)'(1);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        timer_d   = '0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        we_d      = 1'b0;
        done_d    = 1'b0;
        len_d     = len_q;
        timeout_d = 1'b0;
        overrun_d = overrun_q;

        case (state_q)
            IDLE: begin
                if (bus.iArm) begin
                    state_d = COLLECT;
                    cnt_d   = '0;
                end
            end

            COLLECT: begin
                timer_d = timer_sat_inc(timer_q);
                if (bus.iArm) begin
                    // A fresh request restarts the frame; any byte arriving
                    // in the same cycle belongs to the old answer and is dropped.
                    cnt_d   = '0;
                    timer_d = '0;
                end else if (bus.iValid) begin
                    // The byte beats a coincident timeout.
                    we_d      = 1'b1;
                    wr_addr_d = cnt_q[ADDR_W-1:0];
                    wr_data_d = bus.iData;
                    cnt_d     = cnt_inc;
                    timer_d   = '0;
                    if (cnt_inc == FRAME_LEN_C) begin
                        state_d = CLOSE;
                    end
                end else if (timer_q == TMR_LAST) begin
                    timeout_d = 1'b1;
                    timer_d   = '0;
                    state_d   = (cnt_q == '0) ? IDLE : CLOSE;
                end
            end

            CLOSE: begin
                // One cycle so the last ramUART write lands before oDone.
                // The buffer already counts as locked: bytes are dropped and
                // flagged, arm/release wait for LOCKED.
                done_d  = 1'b1;
                len_d   = cnt_q;
                state_d = LOCKED;
                if (bus.iValid) begin
                    overrun_d = 1'b1;
                end
            end

            LOCKED: begin
                if (bus.iRelease) begin
                    // A release is always honoured, even alongside an arm;
                    // only a byte dropped in this very cycle keeps the flag.
                    overrun_d = bus.iValid;
                    if (bus.iArm) begin
                        state_d = COLLECT;
                        cnt_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    if (bus.iValid || bus.iArm) begin
                        overrun_d = 1'b1;
                    end
                    if (bus.iArm) begin
                        state_d = COLLECT;
                        cnt_d   = '0;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            timer_q   <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            we_q      <= 1'b0;
            done_q    <= 1'b0;
            len_q     <= '0;
            timeout_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            timer_q   <= timer_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            we_q      <= we_d;
            done_q    <= done_d;
            len_q     <= len_d;
            timeout_q <= timeout_d;
            overrun_q <= overrun_d;
        end
    end

    assign bus.oWrAddr  = wr_addr_q;
    assign bus.oWrData  = wr_data_q;
    assign bus.oWE      = we_q;
    assign bus.oDone    = done_q;
    assign bus.oLen     = len_q;
    assign bus.oTimeout = timeout_q;
    assign bus.oOverrun = overrun_q;

endmodule

// File: tb/tb_uart_frame_collector.sv
// ----------------------------------------------------------------------------
// tb_uart_frame_collector
//   Drives directed scenarios and randomized traffic into uart_frame_collector
//   and checks every output on every cycle against a frame-level reference
//   model, with literal expectations on the directed scenarios.
// ----------------------------------------------------------------------------
module tb_uart_frame_collector;

    localparam int ADDR_W      = 5;
    localparam int FRAME_LEN   = 16;
    localparam int TIMEOUT_CYC = 400;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    uart_frame_collector_if #(.ADDR_W(ADDR_W)) ifc ();

    uart_frame_collector #(
        .ADDR_W      (ADDR_W),
        .FRAME_LEN   (FRAME_LEN),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: a frame is an open byte list plus a silence count.
    // ------------------------------------------------------------------
    bit          m_open;      // frame accepting bytes
    bit          m_closing;   // frame complete, announcement due next
    bit          m_held;      // buffer waiting for the reader
    int          m_frame[$];  // bytes of the current frame
    int          m_silence;   // cycles since frame start or last byte
    logic        m_we, m_done, m_to, m_ovr;
    logic [31:0] m_addr, m_data, m_len;

    initial begin
        m_open = 0; m_closing = 0; m_held = 0; m_silence = 0;
        m_we = 0; m_done = 0; m_to = 0; m_ovr = 0;
        m_addr = 0; m_data = 0; m_len = 0;
    end

    task automatic m_start();
        m_open    = 1'b1;
        m_silence = 0;
        m_frame.delete();
    endtask

    always @(posedge clk) begin : model_blk
        logic       a, v, r;
        logic [7:0] d;
        a = ifc.iArm; v = ifc.iValid; r = ifc.iRelease; d = ifc.iData;
        m_we = 0; m_done = 0; m_to = 0;
        if (rst) begin
            m_open = 0; m_closing = 0; m_held = 0; m_silence = 0;
            m_frame.delete();
            m_ovr = 0; m_addr = 0; m_data = 0; m_len = 0;
        end else if (m_closing) begin
            m_done    = 1;
            m_len     = m_frame.size();
            m_closing = 0;
            m_held    = 1;
            if (v) m_ovr = 1;
        end else if (m_held) begin
            if (r) begin
                m_held = 0;
                m_ovr  = v;
                if (a) m_start();
            end else begin
                if (v || a) m_ovr = 1;
                if (a) begin
                    m_held = 0;
                    m_start();
                end
            end
        end else if (m_open) begin
            if (a) begin
                m_start();
            end else if (v) begin
                m_we   = 1;
                m_addr = m_frame.size();
                m_data = d;
                m_frame.push_back(d);
                m_silence = 0;
                if (m_frame.size() == FRAME_LEN) begin
                    m_open    = 0;
                    m_closing = 1;
                end
            end else if (m_silence == TIMEOUT_CYC - 1) begin
                m_to   = 1;
                m_open = 0;
                if (m_frame.size() > 0) m_closing = 1;
            end else begin
                m_silence++;
            end
        end else if (a) begin
            m_start();
        end
    end

    // ------------------------------------------------------------------
    // Compare process: every cycle, mid-period.
    // ------------------------------------------------------------------
    int n_we = 0, n_done = 0, n_to = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            check("oWE",      ifc.oWE,      m_we);
            check("oDone",    ifc.oDone,    m_done);
            check("oTimeout", ifc.oTimeout, m_to);
            check("oOverrun", ifc.oOverrun, m_ovr);
            check("oLen",     ifc.oLen,     m_len);
            check("oWrAddr",  ifc.oWrAddr,  m_addr);
            check("oWrData",  ifc.oWrData,  m_data);
            if (ifc.oWE === 1'b1)      n_we++;
            if (ifc.oDone === 1'b1)    n_done++;
            if (ifc.oTimeout === 1'b1) n_to++;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic cyc(input logic a, input logic v, input logic [7:0] d,
                       input logic r, input logic rs = 1'b0);
        ifc.iArm = a; ifc.iValid = v; ifc.iData = d; ifc.iRelease = r; rst = rs;
        @(posedge clk);
        #1;
        ifc.iArm = 0; ifc.iValid = 0; ifc.iData = 0; ifc.iRelease = 0; rst = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 8'h00, 0);
    endtask

    // Runs idle cycles until oTimeout shows, returns the cycle count (bounded).
    task automatic wait_timeout(output int k);
        k = 0;
        while (ifc.oTimeout !== 1'b1 && k < 1000) begin
            cyc(0, 0, 8'h00, 0);
            k++;
        end
    endtask

    initial begin
        int k, base_we, base_done, base_to;
        logic [7:0] bytes3 [3];
        bytes3[0] = 8'hA5; bytes3[1] = 8'h5A; bytes3[2] = 8'hFF;

        ifc.iArm = 0; ifc.iValid = 0; ifc.iData = 0; ifc.iRelease = 0;
        rst = 1;
        repeat (3) @(posedge clk);
        #1;
        rst = 0;
        chk_en = 1;

        check("reset_oWE",      ifc.oWE,      0);
        check("reset_oDone",    ifc.oDone,    0);
        check("reset_oLen",     ifc.oLen,     0);
        check("reset_oWrAddr",  ifc.oWrAddr,  0);
        check("reset_oOverrun", ifc.oOverrun, 0);

        // Full frame, bytes 0x00..0x0F every 167 clk.
        base_to = n_to; base_done = n_done;
        cyc(1, 0, 8'h00, 0);
        for (int i = 0; i < FRAME_LEN; i++) begin
            cyc(0, 1, 8'(i), 0);
            check("full_we",   ifc.oWE,     1);
            check("full_addr", ifc.oWrAddr, i);
            check("full_data", ifc.oWrData, i);
            if (i < FRAME_LEN - 1) idle(166);
        end
        cyc(0, 0, 8'h00, 0);
        check("full_done", ifc.oDone, 1);
        check("full_len",  ifc.oLen,  16);
        idle(2);
        check("full_no_timeout", n_to - base_to,     0);
        check("full_one_done",   n_done - base_done, 1);
        cyc(0, 0, 8'h00, 1);

        // Short frame closed by silence.
        cyc(1, 0, 8'h00, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, bytes3[i], 0);
            check("short_data", ifc.oWrData, bytes3[i]);
            if (i < 2) idle(9);
        end
        wait_timeout(k);
        check("short_timeout_delay", k, 400);
        cyc(0, 0, 8'h00, 0);
        check("short_done", ifc.oDone, 1);
        check("short_len",  ifc.oLen,  3);
        cyc(0, 0, 8'h00, 1);

        // No answer at all.
        idle(2);
        base_we = n_we; base_done = n_done;
        cyc(1, 0, 8'h00, 0);
        wait_timeout(k);
        check("noans_timeout_delay", k, 400);
        check("noans_done_now", ifc.oDone, 0);
        cyc(0, 0, 8'h00, 0);
        check("noans_done_next", ifc.oDone, 0);
        cyc(0, 1, 8'h11, 0);
        check("idle_byte_ignored", ifc.oWE, 0);
        idle(2);
        check("noans_no_we",   n_we - base_we,     0);
        check("noans_no_done", n_done - base_done, 0);

        // Overrun while locked, then release and re-arm.
        cyc(1, 0, 8'h00, 0);
        for (int i = 0; i < FRAME_LEN; i++) begin
            cyc(0, 1, 8'(8'h80 + i), 0);
            cyc(0, 0, 8'h00, 0);
        end
        idle(3);
        cyc(0, 1, 8'h77, 0);
        check("ovr_no_we",  ifc.oWE,      0);
        check("ovr_set",    ifc.oOverrun, 1);
        cyc(0, 0, 8'h00, 1);
        check("ovr_cleared", ifc.oOverrun, 0);
        cyc(1, 0, 8'h00, 0);
        cyc(0, 1, 8'h21, 0);
        check("rearm_we",   ifc.oWE,     1);
        check("rearm_addr", ifc.oWrAddr, 0);

        // Byte coinciding with the timeout cycle wins.
        base_to = n_to;
        idle(TIMEOUT_CYC - 1);
        cyc(0, 1, 8'h42, 0);
        check("coll_we",      ifc.oWE,      1);
        check("coll_addr",    ifc.oWrAddr,  1);
        check("coll_timeout", ifc.oTimeout, 0);
        idle(2);
        check("coll_no_timeout", n_to - base_to, 0);

        // Arm with a byte mid-frame: byte dropped, restart at 0.
        cyc(1, 1, 8'h99, 0);
        check("arm_drop_we", ifc.oWE, 0);
        cyc(0, 1, 8'h3C, 0);
        check("arm_restart_addr", ifc.oWrAddr, 0);
        check("arm_restart_data", ifc.oWrData, 8'h3C);

        // Reset in the middle of a frame.
        cyc(1, 0, 8'h00, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 1, 8'(8'h50 + i), 0);
            idle(2);
        end
        cyc(0, 0, 8'h00, 0, 1);
        check("rst_we",   ifc.oWE,      0);
        check("rst_addr", ifc.oWrAddr,  0);
        check("rst_data", ifc.oWrData,  0);
        check("rst_done", ifc.oDone,    0);
        check("rst_len",  ifc.oLen,     0);
        check("rst_to",   ifc.oTimeout, 0);
        check("rst_ovr",  ifc.oOverrun, 0);
        base_done = n_done; base_to = n_to;
        idle(450);
        check("rst_no_done",    n_done - base_done, 0);
        check("rst_no_timeout", n_to - base_to,     0);
        cyc(1, 0, 8'h00, 0);
        cyc(0, 1, 8'hE7, 0);
        check("rst_rearm_addr", ifc.oWrAddr, 0);

        // Randomized traffic with varying byte density.
        for (int seg = 0; seg < 30; seg++) begin
            int p, pa;
            case ($urandom_range(0, 3))
                0:       p = 2;
                1:       p = 40;
                2:       p = 300;
                default: p = 700;
            endcase
            pa = ($urandom_range(0, 1) == 0) ? 40 : 400;
            for (int c = 0; c < 600; c++) begin
                cyc($urandom_range(0, pa - 1) == 0,
                    $urandom_range(0, p - 1) == 0,
                    8'($urandom),
                    $urandom_range(0, 59) == 0,
                    $urandom_range(0, 2999) == 0);
            end
        end

        idle(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
